// File: rtl/parity_frame_checker.sv
// Serial frame receiver: DATA_BITS data bits (LSB first) followed by one parity bit.
// Reports each completed frame's data and parity result, and counts bad-parity frames.
module parity_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_ok,
    output logic                 frame_valid,
    output logic                 busy,
    output logic [3:0]           err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   sr_q, sr_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   parity_ok_q, parity_ok_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   busy_q, busy_d;
    logic [3:0]             err_cnt_q, err_cnt_d;
    logic [DATA_BITS-1:0]   sr_shifted;
    logic                   frame_ok;

    // New bits enter at the MSB so the first bit ends up in bit 0.
    generate
        if (DATA_BITS > 1) begin : g_shift_wide
            assign sr_shifted = {bit_in, sr_q[DATA_BITS-1:1]};
        end else begin : g_shift_one
            assign sr_shifted = bit_in;
        end
    endgenerate

    assign frame_ok = ((par_q ^ bit_in) == ODD_PARITY);

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        par_d         = par_q;
        data_out_d    = data_out_q;
        parity_ok_d   = parity_ok_q;
        frame_valid_d = 1'b0;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATA;
                    cnt_d   = 5'd0;
                    par_d   = 1'b0;
                end
            end
            DATA: begin
                // abort wins over a bit arriving on the same cycle
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    sr_d  = sr_shifted;
                    par_d = par_q ^ bit_in;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    state_d       = DONE;
                    data_out_d    = sr_q;
                    parity_ok_d   = frame_ok;
                    frame_valid_d = 1'b1;
                    if (!frame_ok && (err_cnt_q != 4'hF)) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DATA) || (state_d == PARITY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            cnt_q         <= 5'd0;
            par_q         <= 1'b0;
            data_out_q    <= '0;
            parity_ok_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_cnt_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            par_q         <= par_d;
            data_out_q    <= data_out_d;
            parity_ok_q   <= parity_ok_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign parity_ok   = parity_ok_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: even- and odd-parity instances share one stimulus stream
// and are checked every cycle against a frame-level model, plus literal expectations.
module tb_parity_frame_checker;

    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;

    logic [DB-1:0] e_data, o_data;
    logic          e_ok, o_ok, e_fv, o_fv, e_busy, o_busy;
    logic [3:0]    e_err, o_err;

    int checks = 0;
    int failures = 0;

    parity_frame_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(e_data), .parity_ok(e_ok), .frame_valid(e_fv),
        .busy(e_busy), .err_cnt(e_err)
    );

    parity_frame_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(o_data), .parity_ok(o_ok), .frame_valid(o_fv),
        .busy(o_busy), .err_cnt(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect bits in a queue, judge parity by counting ones.
    int            phase = 0;  // 0 waiting for start, 1 receiving, 2 result cycle
    int            bits_q[$];
    int            ones;
    logic [DB-1:0] m_data = '0;
    logic          m_ok_e = 1'b0;
    logic          m_ok_o = 1'b0;
    logic          m_fv = 1'b0;
    int            m_err_e = 0;
    int            m_err_o = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            bits_q.delete();
            m_data = '0;
            m_ok_e = 1'b0;
            m_ok_o = 1'b0;
            m_fv = 1'b0;
            m_err_e = 0;
            m_err_o = 0;
        end else begin
            m_fv = 1'b0;
            case (phase)
                0: if (start) begin
                    bits_q.delete();
                    phase = 1;
                end
                1: if (abort) begin
                    phase = 0;
                end else if (bit_valid) begin
                    if (bits_q.size() < DB) begin
                        bits_q.push_back(int'(bit_in));
                    end else begin
                        ones = int'(bit_in);
                        m_data = '0;
                        foreach (bits_q[i]) begin
                            if (bits_q[i] != 0) m_data[i] = 1'b1;
                            ones += bits_q[i];
                        end
                        m_ok_e = (ones % 2) == 0;
                        m_ok_o = (ones % 2) == 1;
                        if (!m_ok_e && m_err_e < 15) m_err_e++;
                        if (!m_ok_o && m_err_o < 15) m_err_o++;
                        m_fv = 1'b1;
                        phase = 2;
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("even_frame_valid", int'(e_fv), int'(m_fv));
        chk("even_data_out", int'(e_data), int'(m_data));
        chk("even_parity_ok", int'(e_ok), int'(m_ok_e));
        chk("even_busy", int'(e_busy), int'(phase == 1));
        chk("even_err_cnt", int'(e_err), m_err_e);
        chk("odd_frame_valid", int'(o_fv), int'(m_fv));
        chk("odd_data_out", int'(o_data), int'(m_data));
        chk("odd_parity_ok", int'(o_ok), int'(m_ok_o));
        chk("odd_busy", int'(o_busy), int'(phase == 1));
        chk("odd_err_cnt", int'(o_err), m_err_o);
    end

    // Ends 1 time unit after the edge that samples the parity bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic p,
                              input int max_gap, input bit mid_start);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DB; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            bit_in = d[i];
            bit_valid = 1'b1;
            if (mid_start && i == 3) start = 1'b1;
            @(negedge clk);
            bit_valid = 1'b0;
            start = 1'b0;
        end
        bit_in = p;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic lit_frame(input string tag, input int data, input int ok, input int err);
        chk({tag, "_fv"}, int'(e_fv), 1);
        chk({tag, "_data"}, int'(e_data), data);
        chk({tag, "_ok"}, int'(e_ok), ok);
        chk({tag, "_err"}, int'(e_err), err);
        @(posedge clk);
        #1;
        chk({tag, "_fv_drop"}, int'(e_fv), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_data", int'(e_data), 0);
        chk("reset_ok", int'(e_ok), 0);
        chk("reset_fv", int'(e_fv), 0);
        chk("reset_busy", int'(e_busy), 0);
        chk("reset_err", int'(e_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // bit_valid while idle must not start anything
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_bits_ignored_busy", int'(e_busy), 0);

        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("a5_good_odd_ok", int'(o_ok), 0);
        lit_frame("a5_good", 'hA5, 1, 0);

        send_frame(8'hA5, 1'b1, 0, 1'b0);
        chk("a5_bad_odd_ok", int'(o_ok), 1);
        lit_frame("a5_bad", 'hA5, 0, 1);

        send_frame(8'h3C, 1'b0, 0, 1'b0);
        lit_frame("3c_good", 'h3C, 1, 1);

        send_frame(8'h01, 1'b1, 2, 1'b1);
        lit_frame("01_gaps", 'h01, 1, 1);

        // abort together with the 6th data bit
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_in = 1'b1;
            bit_valid = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(e_busy), 0);
        chk("abort_fv", int'(e_fv), 0);
        chk("abort_data_kept", int'(e_data), 'h01);
        @(negedge clk);
        abort = 1'b0;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_no_late_fv", int'(e_fv), 0);

        // asynchronous reset between clock edges mid-frame
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            bit_valid = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", int'(e_data), 0);
        chk("async_rst_busy", int'(e_busy), 0);
        chk("async_rst_err", int'(e_err), 0);
        chk("async_rst_ok", int'(e_ok), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        lit_frame("ff_after_rst", 'hFF, 1, 0);

        for (int n = 1; n <= 17; n++) begin
            send_frame(8'h00, 1'b1, 0, 1'b0);
            chk("bad_run_odd_ok", int'(o_ok), 1);
            if (n == 15 || n == 17) chk("err_saturate", int'(e_err), 15);
        end
        chk("odd_err_after_run", int'(o_err), 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal range 1..16).
REQ-002 SHALL have parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a frame; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous frame cancel.
REQ-007 SHALL have port bit_in  input  1  serial data/parity bit, LSB first.
REQ-008 SHALL have port bit_valid  input  1  bit_in is sampled on this cycle's edge.
REQ-009 SHALL have port data_out  output  DATA_BITS  last completed frame's data.
REQ-010 SHALL have port parity_ok  output  1  parity result of the last completed frame.
REQ-011 SHALL have port frame_valid  output  1  one-cycle pulse when data_out/parity_ok update.
REQ-012 SHALL have port busy  output  1  high while in DATA or PARITY.
REQ-013 SHALL have port err_cnt  output  4  saturating count of frames with bad parity.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY and DONE.
REQ-015 SHALL move from IDLE to DATA on start=1, clearing the bit counter and running parity; bit_valid in IDLE is ignored.
REQ-016 SHALL, in DATA, on each bit_valid=1, shift bit_in into the data shift register (first bit -> bit 0), XOR it into running parity and increment the counter; bit_valid=0 cycles hold all state (gaps allowed, no timeout).
REQ-017 SHALL move from DATA to PARITY on the cycle the DATA_BITS-th bit is accepted.
REQ-018 SHALL, in PARITY, on bit_valid=1, compute ok = ((running_parity XOR bit_in) == ODD_PARITY) and move to DONE.
REQ-019 SHALL, in DONE, hold frame_valid=1 for exactly one cycle with data_out and parity_ok updated on the same edge, then return to IDLE unconditionally.
REQ-020 SHALL make frame_valid appear one cycle after the edge on which the parity bit is sampled.
REQ-021 SHALL hold data_out and parity_ok stable between frame_valid pulses; aborted frames never alter them.
REQ-022 SHALL increment err_cnt on the edge that loads parity_ok=0, saturating at 15 without wrap.
REQ-023 SHALL ignore start in DATA, PARITY and DONE (no restart, no counter clear).
REQ-024 SHALL, on abort=1 in DATA or PARITY, return to IDLE on the next edge with no frame_valid and no err_cnt change; abort has priority over simultaneous bit_valid.
REQ-025 SHALL ignore abort in IDLE and DONE; the DONE pulse always completes.
REQ-026 SHALL drive busy=1 exactly in DATA and PARITY, as a registered or state-decoded output with no combinational path from inputs.
REQ-027 SHALL register every output; there is no combinational path from any input to any output.

Reset
REQ-028 SHALL, while rst_n=0, force IDLE, data_out=0, parity_ok=0, frame_valid=0, busy=0, err_cnt=0, clearing the shift register, counter and running parity, independent of clk.
REQ-029 SHALL, on reset assertion mid-frame, discard the partial frame with no frame_valid pulse.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-031 SHALL cover: DATA_BITS=8, even parity, start, bits of 0xA5 LSB first, then parity bit 0 -> one frame_valid pulse, data_out=0xA5, parity_ok=1, err_cnt=0.
REQ-032 SHALL cover: same frame with parity bit 1 -> parity_ok=0, err_cnt=1; next good frame 0x3C with parity 0 -> parity_ok=1, err_cnt stays 1.
REQ-033 SHALL cover: frame 0x01 with bit_valid low on random cycles between bits, plus start pulsed mid-frame -> single frame_valid, data_out=0x01, parity_ok=1 with parity bit 1.
REQ-034 SHALL cover: abort after 5 data bits, coinciding with bit_valid=1 -> IDLE next cycle, no frame_valid, data_out keeps its previous value, busy=0.
REQ-035 SHALL cover: rst_n pulsed low asynchronously (between clk edges) mid-frame -> all outputs zero immediately; next full frame 0xFF with parity 0 -> parity_ok=1.
REQ-036 SHALL cover: 17 consecutive bad-parity frames -> err_cnt reads 15 after the 15th and remains 15; ODD_PARITY=1 build, 0xA5 with parity 1 -> parity_ok=1.
